wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the single register-file write port between the execute unit (EXU) and the load/store unit (LSU). Each source has a small per-source FIFO with a valid/ready handshake. A fixed-priority arbiter favours the LSU and uses a starvation counter so the EXU still gets through. The arbiter drives the registered final writeback bus `rd_wb`, `rd_wb_en` and `rd_wb_data`, which the register file and the trace monitor consume.

## Interface
- `DEPTH`, default 2: entries per source FIFO. Must be a power of two, ≥ 2.
- `STARVE_LIMIT`, default 4: number of consecutive cycles the EXU may be denied while its FIFO is non-empty. Range 1–15.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `exu_valid`  in  1  EXU result offered.
- `exu_ready`  out  1  EXU FIFO can accept.
- `exu_rd`  in  5  destination register.
- `exu_rd_en`  in  1  result writes a register.
- `exu_data`  in  32  result value.
- `lsu_valid`, `lsu_ready`, `lsu_rd`, `lsu_rd_en`, `lsu_data`: same as the EXU ports, for the LSU.
- `rd_wb`  out  5  granted destination register.
- `rd_wb_en`  out  1  write strobe, one cycle per write.
- `rd_wb_data`  out  32  write data.
- `wb_pending`  out  1  either FIFO is non-empty, or `rd_wb_en` is high.

## Operation
Input handshake:
- A transfer occurs on a rising edge where `valid && ready` is true.
- `ready` is the negation of that source's FIFO full flag. It is computed from the count only; a same-cycle pop does not open a slot.
- `ready` is 0 while `reset` is high.
- A transfer with `rd_en == 0` or `rd == 0` is accepted and discarded. It never occupies a slot and never produces `rd_wb_en`.

FIFOs:
- One FIFO per source, each `DEPTH` entries wide, holding {rd, data}.
- Read and write pointers have `log2(DEPTH)+1` bits and wrap modulo `2*DEPTH`.
- full = (pointers differ only in the MSB). empty = (pointers are equal).

Arbitration is evaluated every cycle on FIFO heads:
- Neither FIFO has data: no grant; `rd_wb_en` goes to 0 on the next edge.
- Only one FIFO has data: that source is granted.
- Both have data: the LSU is granted, unless `starve_cnt == STARVE_LIMIT`, in which case the EXU is granted.

Starvation counter `starve_cnt` (4 bits):
- Increments, saturating at `STARVE_LIMIT`, on each edge where the EXU FIFO is non-empty and the EXU is not granted.
- Clears to 0 on an EXU grant, or whenever the EXU FIFO is empty.

Grant action:
- Pops the head of the granted FIFO.
- On the same edge, loads {`rd_wb`, `rd_wb_data`} from that head and sets `rd_wb_en` = 1.

Ordering:
- Order is preserved within each source.
- Order across sources is not guaranteed. Upstream guarantees that no two in-flight writes from different sources target the same rd.

## Timing
Reset:
- All outputs are 0: `rd_wb`, `rd_wb_en`, `rd_wb_data`, `wb_pending`, `exu_ready`, `lsu_ready`.
- FIFO pointers are 0 and `starve_cnt` is 0.
- A reset asserted mid-operation discards all queued entries. No writeback is issued on the cycle after reset.
- From the first cycle after reset deassertion, both `ready` outputs are 1.

Latency and throughput:
- A transfer on the edge ending cycle N produces `rd_wb_en` high during cycle N+2 if that source wins at its first arbitration.
- There is no combinational path from any input to `rd_wb_*`.
- Throughput is one writeback per cycle across both sources.
- Each source sustains one transfer per cycle only while its FIFO is not full.

Simultaneous events:
- A push and a pop on the same FIFO in one cycle are both performed; the count is unchanged.
- A push to a full FIFO cannot occur, because `ready` is 0.

Outputs:
- `rd_wb_en` is high for exactly one cycle per granted entry.
- `rd_wb` and `rd_wb_data` hold their last value when `rd_wb_en` is 0.

## Test plan
- **Reset.** Assert `reset` for 3 cycles while `exu_valid=1`, rd=5 → `rd_wb_en` stays 0 and both `ready` outputs are 0. After release, `ready`=1. The first accepted write, rd=5, data=0x11, appears 2 cycles after its transfer.
- **Single source streaming.** LSU sends rd=1..4, data 0xA1..0xA4 on back-to-back cycles → `rd_wb_en` is high for 4 consecutive cycles with rd 1,2,3,4 in order. `lsu_ready` never drops, because occupancy never exceeds 1.
- **Contention and starvation.** EXU and LSU both push continuously (LSU rd=2, EXU rd=3), `STARVE_LIMIT`=4 → the output pattern repeats LSU ×4 then EXU ×1. The EXU never waits more than 5 cycles after reaching its FIFO head.
- **Full / backpressure.** Hold the LSU busy so the EXU is never granted; EXU pushes 3 entries with `DEPTH`=2 → `exu_ready`=0 after the 2nd transfer and the 3rd is held. After drain, all 3 EXU writes appear, in order.
- **Discard rules.** EXU sends rd=0 data=0xFFFF_FFFF, then rd=7 with `rd_en`=0 → both are accepted (`ready` stays 1), no `rd_wb_en` pulse is produced, and `wb_pending` stays 0.
- **Reset mid-operation.** With 2 entries queued in each FIFO, pulse `reset` for one cycle → no writebacks follow, and `wb_pending`=0 on the cycle after reset.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the EXU and the LSU.
// Each source is buffered in a small FIFO; the LSU wins ties unless the EXU has starved.

module wb_src_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [4:0]  o_rd,
    output logic [31:0] o_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] MSB_ONLY = {1'b1, {AW{1'b0}}};

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];

    // Extra pointer bit separates full from empty when the indices match.
    assign o_full  = ((r_wr_ptr ^ r_rd_ptr) == MSB_ONLY);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rd    = r_mem_rd[r_rd_ptr[AW-1:0]];
    assign o_data  = r_mem_data[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem_rd[r_wr_ptr[AW-1:0]]   <= i_rd;
            r_mem_data[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end
endmodule

module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_exu_valid,
    output logic        o_exu_ready,
    input  logic [4:0]  i_exu_rd,
    input  logic        i_exu_rd_en,
    input  logic [31:0] i_exu_data,
    input  logic        i_lsu_valid,
    output logic        o_lsu_ready,
    input  logic [4:0]  i_lsu_rd,
    input  logic        i_lsu_rd_en,
    input  logic [31:0] i_lsu_data,
    output logic [4:0]  o_rd_wb,
    output logic        o_rd_wb_en,
    output logic [31:0] o_rd_wb_data,
    output logic        o_wb_pending
);
    localparam int NSRC = 2;
    localparam int EXU  = 0;
    localparam int LSU  = 1;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [NSRC-1:0]        w_valid;
    logic [NSRC-1:0]        w_rd_en;
    logic [NSRC-1:0][4:0]   w_in_rd;
    logic [NSRC-1:0][31:0]  w_in_data;
    logic [NSRC-1:0]        w_ready;
    logic [NSRC-1:0]        w_push;
    logic [NSRC-1:0]        w_gnt;
    logic [NSRC-1:0]        w_full;
    logic [NSRC-1:0]        w_empty;
    logic [NSRC-1:0][4:0]   w_head_rd;
    logic [NSRC-1:0][31:0]  w_head_data;

    logic [3:0]  r_starve_cnt;
    logic [4:0]  r_rd_wb;
    logic        r_rd_wb_en;
    logic [31:0] r_rd_wb_data;

    assign w_valid   = {i_lsu_valid, i_exu_valid};
    assign w_rd_en   = {i_lsu_rd_en, i_exu_rd_en};
    assign w_in_rd   = {i_lsu_rd, i_exu_rd};
    assign w_in_data = {i_lsu_data, i_exu_data};

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        // Writes to x0 or with rd_en low are acknowledged but never stored.
        assign w_ready[s] = !w_full[s] && !i_reset;
        assign w_push[s]  = w_valid[s] && w_ready[s] && w_rd_en[s] && (w_in_rd[s] != 5'd0);

        wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_push  (w_push[s]),
            .i_pop   (w_gnt[s]),
            .i_rd    (w_in_rd[s]),
            .i_data  (w_in_data[s]),
            .o_full  (w_full[s]),
            .o_empty (w_empty[s]),
            .o_rd    (w_head_rd[s]),
            .o_data  (w_head_data[s])
        );
    end

    assign o_exu_ready = w_ready[EXU];
    assign o_lsu_ready = w_ready[LSU];

    always_comb begin
        w_gnt = '0;
        if (!w_empty[LSU] && !(!w_empty[EXU] && r_starve_cnt == LIMIT))
            w_gnt[LSU] = 1'b1;
        else if (!w_empty[EXU])
            w_gnt[EXU] = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || w_empty[EXU] || w_gnt[EXU])
            r_starve_cnt <= '0;
        else if (r_starve_cnt != LIMIT)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    // rd/data hold their last value between strobes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_wb      <= '0;
            r_rd_wb_en   <= 1'b0;
            r_rd_wb_data <= '0;
        end else begin
            r_rd_wb_en <= |w_gnt;
            if (w_gnt[LSU]) begin
                r_rd_wb      <= w_head_rd[LSU];
                r_rd_wb_data <= w_head_data[LSU];
            end else if (w_gnt[EXU]) begin
                r_rd_wb      <= w_head_rd[EXU];
                r_rd_wb_data <= w_head_data[EXU];
            end
        end
    end

    assign o_rd_wb      = r_rd_wb;
    assign o_rd_wb_en   = r_rd_wb_en;
    assign o_rd_wb_data = r_rd_wb_data;
    assign o_wb_pending = !w_empty[EXU] || !w_empty[LSU] || r_rd_wb_en;
endmodule
